// File: rtl/majority_pattern_gen_pkg.sv
// Purpose: shared types, weight constants and per-weight pattern lookups for
//          the majority pattern generator.
// Ports:   none (package).
package majority_pattern_pkg;

  localparam int unsigned PAT_W = 3;
  localparam int unsigned K_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [K_W-1:0] K_ZERO  = 2'd0;
  localparam logic [K_W-1:0] K_ONE   = 2'd1;
  localparam logic [K_W-1:0] K_TWO   = 2'd2;
  localparam logic [K_W-1:0] K_THREE = 2'd3;

  // Indexed by k: entry [k] is the first / last pattern of weight k.
  localparam logic [3:0][PAT_W-1:0] FIRST_PAT = {3'b111, 3'b011, 3'b001, 3'b000};
  localparam logic [3:0][PAT_W-1:0] LAST_PAT  = {3'b111, 3'b110, 3'b100, 3'b000};

  // Number of ones in a 3-bit pattern (max 3 fits in K_W bits).
  function automatic logic [K_W-1:0] weight(input logic [PAT_W-1:0] p);
    return K_W'(p[0]) + K_W'(p[1]) + K_W'(p[2]);
  endfunction

endpackage

// File: rtl/majority_pattern_gen_if.sv
// Purpose: request/response bundle between a stimulus consumer and the
//          majority pattern generator.
// Ports:   req_val/req_rdy/req_k request channel; resp_val/resp_rdy plus
//          out0..2, resp_maj, resp_last payload; pat_count status.
//          slave = generator side, master = consumer side.
interface majority_pattern_gen_if #(
  parameter int unsigned CNT_W = 8
) ();

  logic             req_val;
  logic             req_rdy;
  logic [1:0]       req_k;
  logic             resp_val;
  logic             resp_rdy;
  logic             out0;
  logic             out1;
  logic             out2;
  logic             resp_maj;
  logic             resp_last;
  logic [CNT_W-1:0] pat_count;

  modport slave (
    input  req_val, req_k, resp_rdy,
    output req_rdy, resp_val, out0, out1, out2, resp_maj, resp_last, pat_count
  );

  modport master (
    output req_val, req_k, resp_rdy,
    input  req_rdy, resp_val, out0, out1, out2, resp_maj, resp_last, pat_count
  );

endinterface

// File: rtl/majority_pattern_gen_step.sv
// Purpose: combinational successor of a 3-bit pattern within its weight class.
// Ports:   i_pat      current pattern
//          o_pat_nxt  next pattern of the same weight (held if none)
//          o_is_last  i_pat is the final pattern of its weight sequence
module majority_pattern_step
  import majority_pattern_pkg::*;
(
  input  logic [PAT_W-1:0] i_pat,
  output logic [PAT_W-1:0] o_pat_nxt,
  output logic             o_is_last
);

  // Ascending order within each weight class.
  always_comb begin
    o_pat_nxt = i_pat;
    case (i_pat)
      3'b001:  o_pat_nxt = 3'b010;
      3'b010:  o_pat_nxt = 3'b100;
      3'b011:  o_pat_nxt = 3'b101;
      3'b101:  o_pat_nxt = 3'b110;
      default: o_pat_nxt = i_pat;
    endcase
  end

  assign o_is_last = (i_pat == LAST_PAT[weight(i_pat)]);

endmodule

// File: rtl/majority_pattern_gen.sv
// Purpose: emits every 3-bit pattern of a requested weight k in ascending
//          order, one per response handshake, tagged with its majority bit.
// Ports:   clk, rst_n (async, active-low)
//          bus (slave): req_val/req_rdy/req_k in, resp_val/resp_rdy handshake,
//          out0..2 pattern, resp_maj (k>=2), resp_last, pat_count (saturating)
module majority_pattern_gen
  import majority_pattern_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  majority_pattern_gen_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_req_rdy;
  logic             r_resp_val;
  logic [PAT_W-1:0] r_pat;
  logic [K_W-1:0]   r_k;
  logic             r_maj;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt;
  logic [PAT_W-1:0] w_pat_step;
  logic             w_is_last;
  logic             w_accept;
  logic             w_hs;

  majority_pattern_step u_step (
    .i_pat     (r_pat),
    .o_pat_nxt (w_pat_step),
    .o_is_last (w_is_last)
  );

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_hs        = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req_val && r_req_rdy) begin
          w_accept    = 1'b1;
          w_state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (r_resp_val && bus.resp_rdy) begin
          w_hs = 1'b1;
          if (w_is_last) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register; ready/valid registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_req_rdy  <= 1'b1;
      r_resp_val <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_req_rdy  <= (w_state_nxt == IDLE);
      r_resp_val <= (w_state_nxt == EMIT);
    end
  end

  // Pattern payload: load on accept, advance on non-final handshake, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat  <= '0;
      r_k    <= K_ZERO;
      r_maj  <= 1'b0;
      r_last <= 1'b0;
    end else if (w_accept) begin
      r_k    <= bus.req_k;
      r_pat  <= FIRST_PAT[bus.req_k];
      r_maj  <= bus.req_k[1];
      r_last <= (FIRST_PAT[bus.req_k] == LAST_PAT[bus.req_k]);
    end else if (w_hs && !w_is_last) begin
      r_pat  <= w_pat_step;
      r_last <= (w_pat_step == LAST_PAT[r_k]);
    end
  end

  // Saturating handshake counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_hs && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.req_rdy   = r_req_rdy;
  assign bus.resp_val  = r_resp_val;
  assign bus.out0      = r_pat[0];
  assign bus.out1      = r_pat[1];
  assign bus.out2      = r_pat[2];
  assign bus.resp_maj  = r_maj;
  assign bus.resp_last = r_last;
  assign bus.pat_count = r_cnt;

endmodule

// File: tb/tb_majority_pattern_gen.sv
// Purpose: self-checking bench for majority_pattern_gen: directed scenarios
//          with literal expectations plus randomized traffic, all checked
//          every cycle against a list-based behavioural model.
module tb_majority_pattern_gen;

  localparam int unsigned CNT_W = 2;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  majority_pattern_gen_if #(.CNT_W(CNT_W)) bus ();

  majority_pattern_gen #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the sequence is the ascending list of 3-bit values
  // whose popcount equals k; an index walks it on each consumer-ready cycle.
  bit       m_busy = 1'b0;
  int       m_list[$];
  int       m_idx  = 0;
  int       m_pat  = 0;
  bit       m_last = 1'b0;
  bit       m_maj  = 1'b0;
  int       m_cnt  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_pat  = 0;
      m_last = 1'b0;
      m_maj  = 1'b0;
      m_cnt  = 0;
      m_idx  = 0;
    end else if (!m_busy) begin
      if (bus.req_val) begin
        m_list.delete();
        for (int v = 0; v < 8; v++)
          if ($countones(3'(v)) == int'(bus.req_k)) m_list.push_back(v);
        m_idx  = 0;
        m_busy = 1'b1;
        m_pat  = m_list[0];
        m_last = (m_list.size() == 1);
        m_maj  = (int'(bus.req_k) >= 2);
      end
    end else if (bus.resp_rdy) begin
      if (m_cnt < CMAX) m_cnt = m_cnt + 1;
      if (m_idx == m_list.size() - 1) begin
        m_busy = 1'b0;
      end else begin
        m_idx  = m_idx + 1;
        m_pat  = m_list[m_idx];
        m_last = (m_idx == m_list.size() - 1);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("req_rdy",   int'(bus.req_rdy),   int'(!m_busy));
    check("resp_val",  int'(bus.resp_val),  int'(m_busy));
    check("pattern",   int'({bus.out2, bus.out1, bus.out0}), m_pat);
    check("resp_maj",  int'(bus.resp_maj),  int'(m_maj));
    check("resp_last", int'(bus.resp_last), int'(m_last));
    check("pat_count", int'(bus.pat_count), m_cnt);
    if (bus.resp_val)
      check("maj_of_pattern", int'(bus.resp_maj),
            int'($countones({bus.out2, bus.out1, bus.out0}) >= 2));
  end

  // Handshaken payloads as {maj, last, out2, out1, out0}.
  int log_q[$];

  task automatic tick(input bit rv, input int rk, input bit rr);
    @(negedge clk);
    #1;
    bus.req_val  = rv;
    bus.req_k    = 2'(rk);
    bus.resp_rdy = rr;
    if (bus.resp_val && rr)
      log_q.push_back(int'({bus.resp_maj, bus.resp_last, bus.out2, bus.out1, bus.out0}));
  endtask

  // Reset asserted in the middle of the high phase; outputs must clear at once.
  task automatic mid_cycle_reset();
    @(posedge clk);
    #2;
    bus.req_val = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_req_rdy",   int'(bus.req_rdy),   1);
    check("rst_resp_val",  int'(bus.resp_val),  0);
    check("rst_pat_count", int'(bus.pat_count), 0);
    check("rst_pattern",   int'({bus.out2, bus.out1, bus.out0}), 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_log(input string name, input int exp[$]);
    check({name, "_len"}, log_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < log_q.size(); i++)
      check(name, log_q[i], exp[i]);
  endtask

  initial begin
    bus.req_val  = 1'b0;
    bus.req_k    = 2'd0;
    bus.resp_rdy = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // k=1, consumer always ready.
    log_q.delete();
    tick(1, 1, 1);
    repeat (3) tick(0, 0, 1);
    check_log("k1_seq", '{1, 2, 12});
    tick(0, 0, 0);
    check("k1_rdy_back", int'(bus.req_rdy), 1);

    // k=2 with a three-cycle stall on 101.
    log_q.delete();
    tick(1, 2, 1);
    tick(0, 3, 1);
    repeat (3) begin
      tick(0, 1, 0);
      check("k2_stall_pat", int'({bus.out2, bus.out1, bus.out0}), 5);
    end
    tick(0, 0, 1);
    tick(0, 0, 1);
    tick(0, 0, 0);
    check_log("k2_seq", '{19, 21, 30});

    // k=0 then k=3 back to back, with the IDLE gap in between.
    log_q.delete();
    tick(1, 0, 1);
    tick(1, 3, 1);
    tick(1, 3, 1);
    check("gap_rdy", int'(bus.req_rdy), 1);
    check("gap_val", int'(bus.resp_val), 0);
    tick(0, 0, 1);
    tick(0, 0, 0);
    check_log("k0_k3_seq", '{8, 31});

    // Saturation: four k=1 requests with req_val held high during EMIT.
    mid_cycle_reset();
    for (int r = 0; r < 4; r++) begin
      tick(1, 1, 1);
      if (r > 0) check("sat_count", int'(bus.pat_count), 3);
      repeat (3) tick(1, int'($urandom_range(0, 3)), 1);
    end
    tick(0, 0, 0);
    check("sat_final", int'(bus.pat_count), 3);

    // Reset while 010 is shown, then a fresh k=1 restarts at 001.
    tick(1, 1, 1);
    tick(0, 0, 1);
    mid_cycle_reset();
    log_q.delete();
    tick(1, 1, 1);
    tick(0, 0, 1);
    check_log("restart_seq", '{1});
    repeat (3) tick(0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      tick(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           bit'($urandom_range(0, 3) != 0));

    tick(0, 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
